// File: rtl/bram_writer_in.sv
// Stream-to-frame-buffer writer: writes SOF-aligned frames into alternating BRAM banks
// and hands each completed bank to the reader, never overrunning the bank being read.
module bram_writer_in #(
   parameter int unsigned width      = 120,
   parameter int unsigned height     = 240,
   parameter int unsigned frame_size = width * height,
   parameter int unsigned addr_bits  = $clog2(frame_size),
   parameter int unsigned data_width = 21
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [data_width-1:0] in_data,
   input  logic                  in_sof,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  wr_en,
   output logic                  wr_bram_index,
   output logic [addr_bits-1:0]  wr_address,
   output logic [data_width-1:0] wr_data,
   input  logic                  reader_idle,
   input  logic                  reader_bram_index,
   output logic                  frame_done,
   output logic                  frame_bram_index,
   output logic [7:0]            sync_errors
);

   typedef enum logic [1:0] {ST_SYNC, ST_RUNNING, ST_WAIT_BANK} state_t;

   localparam logic [addr_bits-1:0] LAST_ADDR = addr_bits'(frame_size - 1);

   state_t               state, state_nxt;
   logic [addr_bits-1:0] addr, addr_nxt;
   logic                 bank, bank_nxt;
   logic                 accept;
   logic                 do_write;
   logic [addr_bits-1:0] wr_addr_nxt;
   logic                 done_nxt;
   logic                 err_inc;
   logic                 next_bank_free;
   logic                 cur_bank_free;

   assign in_ready       = reset_n && (state != ST_WAIT_BANK);
   assign accept         = in_valid && in_ready;
   assign next_bank_free = reader_idle || (reader_bram_index != ~bank);
   assign cur_bank_free  = reader_idle || (reader_bram_index != bank);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_SYNC;
         addr  <= '0;
         bank  <= 1'b0;
      end else begin
         state <= state_nxt;
         addr  <= addr_nxt;
         bank  <= bank_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      addr_nxt    = addr;
      bank_nxt    = bank;
      do_write    = 1'b0;
      wr_addr_nxt = addr;
      done_nxt    = 1'b0;
      err_inc     = 1'b0;
      unique case (state)
         ST_SYNC: begin
            if (accept) begin
               if (in_sof) begin
                  do_write    = 1'b1;
                  wr_addr_nxt = '0;
                  addr_nxt    = addr_bits'(1);
                  state_nxt   = ST_RUNNING;
               end else begin
                  err_inc = 1'b1;
               end
            end
         end
         ST_RUNNING: begin
            if (accept) begin
               do_write = 1'b1;
               // SOF mid-frame (including on the last address) restarts the same bank
               if (in_sof && addr != '0) begin
                  wr_addr_nxt = '0;
                  addr_nxt    = addr_bits'(1);
                  err_inc     = 1'b1;
               end else if (addr == LAST_ADDR) begin
                  done_nxt  = 1'b1;
                  bank_nxt  = ~bank;
                  addr_nxt  = '0;
                  state_nxt = next_bank_free ? ST_SYNC : ST_WAIT_BANK;
               end else begin
                  addr_nxt = addr + addr_bits'(1);
               end
            end
         end
         ST_WAIT_BANK: begin
            if (cur_bank_free) state_nxt = ST_SYNC;
         end
         default: state_nxt = ST_SYNC;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_en            <= 1'b0;
         wr_address       <= '0;
         wr_data          <= '0;
         wr_bram_index    <= 1'b0;
         frame_done       <= 1'b0;
         frame_bram_index <= 1'b0;
         sync_errors      <= '0;
      end else begin
         wr_en      <= do_write;
         frame_done <= done_nxt;
         if (do_write) begin
            wr_address    <= wr_addr_nxt;
            wr_data       <= in_data;
            wr_bram_index <= bank;
         end
         if (done_nxt) frame_bram_index <= bank;
         if (err_inc && sync_errors != '1) sync_errors <= sync_errors + 8'd1;
      end
   end

endmodule

// File: doc/bram_writer_in.md
# bram_writer_in

Stream-to-frame-buffer writer for the disparity filtering path. Accepts a valid/ready pixel stream with a start-of-frame flag and writes each frame sequentially into one bank of a double-buffered BRAM. Banks alternate automatically. On frame completion it pulses `frame_done` with the completed bank index; that pair drives the output reader's `start` / `bram_index_in`. It never starts writing a bank that the reader is still reading.

## Interface
- `width`, 120, pixels per line
- `height`, 240, lines per frame
- `frame_size`, `width*height`, words per frame
- `addr_bits`, `$clog2(frame_size)`, BRAM address width
- `data_width`, 21, pixel word width

- `clk`  in  1  sole clock
- `reset_n`  in  1  asynchronous, active-low reset
- `in_data`  in  data_width  stream pixel
- `in_sof`  in  1  marks first pixel of a frame; qualified by `in_valid`
- `in_valid`  in  1  stream valid
- `in_ready`  out  1  stream ready
- `wr_en`  out  1  BRAM write strobe
- `wr_bram_index`  out  1  bank being written
- `wr_address`  out  addr_bits  BRAM write address
- `wr_data`  out  data_width  BRAM write data
- `reader_idle`  in  1  reader's `idle`
- `reader_bram_index`  in  1  bank the reader is currently reading
- `frame_done`  out  1  one-cycle pulse: bank `frame_bram_index` holds a complete frame
- `frame_bram_index`  out  1  completed bank, held until next `frame_done`
- `sync_errors`  out  8  saturating count of protocol errors

## Operation
- Beat accepted ⇔ `in_valid && in_ready`. `in_ready` = (state != ST_WAIT_BANK). It is 0 while `reset_n` is low.
- Internal write counter `addr` runs 0..frame_size-1. Internal bank `bank` resets to 0.
- **ST_SYNC** (reset state):
  - Accepted beats without `in_sof` are discarded. No write occurs, and `sync_errors` increments.
  - An accepted beat with `in_sof` is written at address 0 of `bank`. `addr` becomes 1 and the state moves to ST_RUNNING.
- **ST_RUNNING**:
  - Accepted beat without `in_sof`: written at `addr`, then `addr` increments.
  - Accepted beat with `in_sof` and `addr` != 0: premature SOF. It is written at address 0, `addr` becomes 1, and `sync_errors` increments. The frame restarts in the same bank and no `frame_done` is issued.
  - Accepted beat at `addr` == frame_size-1, with no SOF: the final write. `frame_done` pulses with `frame_bram_index` = `bank`. `bank` toggles and `addr` becomes 0.
  - After the final write, the next state is ST_SYNC if the new bank is free, otherwise ST_WAIT_BANK. "Free" means `reader_idle` || `reader_bram_index` != new bank, evaluated in the same cycle as the final beat.
- **ST_WAIT_BANK**: `in_ready`=0. Moves to ST_SYNC on the first cycle the new bank is free.
- `sync_errors` saturates at 255 and never wraps.
- `wr_bram_index` for every write equals the `bank` value at the time the beat was accepted.

## Timing
- Reset values: `wr_en`=0, `wr_address`=0, `wr_data`=0, `wr_bram_index`=0, `frame_done`=0, `frame_bram_index`=0, `sync_errors`=0, `in_ready`=0, state ST_SYNC.
- Write latency: accepted beat in cycle N produces registered `wr_en`/`wr_address`/`wr_data`/`wr_bram_index` in cycle N+1. `wr_en`=0 in every cycle that follows a non-written cycle.
- `frame_done` is registered and asserts in the same cycle as the final `wr_en` (N+1). It pulses exactly once per completed frame.
- The bank-free check is sampled in cycle N, so the earliest accept into the new bank is N+1.
- Full throughput is one beat per clock while in ST_SYNC/ST_RUNNING. `in_valid` low stalls with no state change.
- Asserting `reset_n` low mid-frame clears everything immediately (asynchronously). The partial frame is abandoned and no `frame_done` is issued.
- An SOF on the final-address beat takes the premature-SOF path: the frame restarts and `addr` becomes 1.

## Test plan
- **Bank ping-pong:** width=4, height=2, `reader_idle`=1; two frames of 8 beats with SOF on beat 0, `in_valid` held high. Required: 16 writes, addresses 0..7 each; bank 0 then bank 1. `frame_done` pulses at write 8 (index 0) and write 16 (index 1). `sync_errors`=0.
- **Pre-sync garbage:** 3 non-SOF beats, then a valid frame. Required: no `wr_en` for the first 3 beats, `sync_errors`=3, then a normal frame into bank 0.
- **Premature SOF:** SOF at beat 5 of frame 1. Required: 5 writes, then a write at address 0, `sync_errors`=1. `frame_done` fires only after 8 more consecutive beats, at bank 0.
- **Bank blocked:** after frame 0 completes, `reader_idle`=0 and `reader_bram_index`=1. Required: `in_ready`=0 until `reader_bram_index`=0 or `reader_idle`=1; the next accept occurs the cycle after release.
- **Backpressure and stalls:** random `in_valid` gaps. Required: write addresses contiguous, data in order, `frame_done` once per frame.
- **Async reset mid-frame:** `reset_n` low at beat 4. Required: outputs go to reset values without a clock edge. After release, a full frame is written into bank 0 from address 0.
